lzd_scheduler: RTL and testbench

LZD_SCHEDULER -- requirements
Module: lzd_scheduler

---
 rtl/lzd_scheduler.sv | 152 +++++++++++++++
 tb/tb_lzd_scheduler.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lzd_scheduler.sv
// Round-robin scheduler sharing one leading-one detector/normalizer among N_REQ requesters.
// Latency: grant cycle, one calc cycle, result held in OUT until res_ready; requesters wait while busy.
module lzd_scheduler #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_l,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*WIDTH-1:0]     req_data,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [$clog2(WIDTH)-1:0]   res_index,
  output logic                       res_zero,
  output logic [WIDTH-1:0]           res_norm,
  output logic [$clog2(N_REQ)-1:0]   res_tag,
  output logic                       busy
);

  localparam int IW = $clog2(WIDTH);
  localparam int TW = $clog2(N_REQ);

  generate
    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
      $error("lzd_scheduler: N_REQ must be 2..8");
    end
    if (WIDTH < 8 || WIDTH > 64 || (1 << IW) != WIDTH) begin : g_bad_width
      $error("lzd_scheduler: WIDTH must be a power of two in 8..64");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2
  } state_t;

  typedef struct packed {
    logic [TW-1:0]    tag;
    logic [IW-1:0]    index;
    logic             zero;
    logic [WIDTH-1:0] norm;
  } res_t;

  state_t           state, state_nxt;
  logic [TW-1:0]    rr_ptr;
  logic [TW-1:0]    grant_idx;
  logic             grant_found;
  logic [N_REQ-1:0] grant_onehot;
  logic [WIDTH-1:0] op_sel;
  logic [WIDTH-1:0] op_q;
  logic [TW-1:0]    tag_q;
  logic [IW-1:0]    lzd_index;
  logic             lzd_zero;
  logic [WIDTH-1:0] lzd_norm;
  res_t             res_q;

  // Search upward from rr_ptr with wrap; the first valid requester wins.
  always_comb begin
    int cand;
    cand        = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = TW'(cand);
      end
    end
  end

  assign grant_onehot = N_REQ'(1) << grant_idx;
  assign op_sel       = req_data[int'(grant_idx)*WIDTH +: WIDTH];

  // Leading-one detector on the captured operand; a zero operand shifts to zero.
  always_comb begin
    lzd_index = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (op_q[i]) lzd_index = IW'(i);
    end
    lzd_zero = ~|op_q;
    lzd_norm = op_q << (IW'(WIDTH-1) - lzd_index);
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_found) state_nxt = CALC;
      CALC:    state_nxt = OUT;
      OUT:     if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    res_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (rst_l && grant_found) req_ready = grant_onehot;
      end
      CALC: busy = 1'b1;
      OUT: begin
        busy      = 1'b1;
        res_valid = 1'b1;
      end
      default: busy = 1'b1;
    endcase
  end

  // Operand and tag are sampled only on the grant edge, so later req_data changes cannot leak in.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rr_ptr <= '0;
      op_q   <= '0;
      tag_q  <= '0;
    end else if (state == IDLE && grant_found) begin
      op_q   <= op_sel;
      tag_q  <= grant_idx;
      rr_ptr <= (grant_idx == TW'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      res_q <= '0;
    end else if (state == CALC) begin
      res_q.tag   <= tag_q;
      res_q.index <= lzd_index;
      res_q.zero  <= lzd_zero;
      res_q.norm  <= lzd_norm;
    end
  end

  assign res_index = res_q.index;
  assign res_zero  = res_q.zero;
  assign res_norm  = res_q.norm;
  assign res_tag   = res_q.tag;

endmodule

// File: tb/tb_lzd_scheduler.sv
// Scoreboard bench for lzd_scheduler: expected results queued at grant, compared when res_valid appears.
module tb_lzd_scheduler;

  logic         clk = 1'b0;
  logic         rst_l;
  logic [3:0]   req_valid;
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic         res_valid;
  logic         res_ready;
  logic [4:0]   res_index;
  logic         res_zero;
  logic [31:0]  res_norm;
  logic [1:0]   res_tag;
  logic         busy;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct packed {
    logic [1:0]  tag;
    logic [4:0]  index;
    logic        zero;
    logic [31:0] norm;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  lzd_scheduler #(.N_REQ(4), .WIDTH(32)) dut (
    .clk       (clk),
    .rst_l     (rst_l),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_index (res_index),
    .res_zero  (res_zero),
    .res_norm  (res_norm),
    .res_tag   (res_tag),
    .busy      (busy)
  );

  // Reference: index = floor(log2(d)) via ceil-log2 of d+1, norm = d << (31-index).
  function automatic exp_t model(input logic [31:0] d, input logic [1:0] t);
    exp_t e;
    int   idx;
    e.tag = t;
    if (d == 32'h0) begin
      e.index = 5'd0;
      e.zero  = 1'b1;
      e.norm  = 32'h0;
    end else begin
      idx     = $clog2({32'h0, d} + 64'd1) - 1;
      e.index = 5'(idx);
      e.zero  = 1'b0;
      e.norm  = d << (31 - idx);
    end
    return e;
  endfunction

  function automatic exp_t observed();
    return {res_tag, res_index, res_zero, res_norm};
  endfunction

  task automatic test_reset();
    @(negedge clk);
    #1;
    n_total++;
    if (req_ready !== 4'b0000) $display("FAIL reset_ready: got %b want 0000", req_ready);
    else n_pass++;
    n_total++;
    if ({res_valid, busy} !== 2'b00) $display("FAIL reset_flags: got valid=%b busy=%b want 0 0", res_valid, busy);
    else n_pass++;
    n_total++;
    if (observed() !== '0) $display("FAIL reset_res: got %h want 0", observed());
    else n_pass++;
    req_valid = 4'b0000;
    @(negedge clk);
    rst_l = 1'b1;
  endtask

  task automatic test_single();
    exp_t e;
    @(negedge clk);
    res_ready = 1'b1;
    req_data[31:0] = 32'h0000_0001;
    req_valid = 4'b0001;
    #1;
    n_total++;
    if (req_ready !== 4'b0001) $display("FAIL single_grant: got %b want 0001", req_ready);
    else n_pass++;
    sb.push_back({2'd0, 5'd0, 1'b0, 32'h8000_0000});
    @(negedge clk);
    req_valid = 4'b0000;
    n_total++;
    if ({res_valid, busy, req_ready} !== {1'b0, 1'b1, 4'b0000})
      $display("FAIL single_calc: got valid=%b busy=%b ready=%b want 0 1 0000", res_valid, busy, req_ready);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (res_valid !== 1'b1) $display("FAIL single_latency: got res_valid=%b want 1", res_valid);
    else n_pass++;
    n_total++;
    if (sb.size() == 0) $display("FAIL single_result: scoreboard empty");
    else begin
      e = sb.pop_front();
      if (observed() !== e) $display("FAIL single_result: got %h want %h", observed(), e);
      else n_pass++;
    end
    @(negedge clk);
    n_total++;
    if (busy !== 1'b0) $display("FAIL single_idle: got busy=%b want 0", busy);
    else n_pass++;
  endtask

  task automatic test_values();
    logic [31:0] vals [3];
    exp_t        exps [3];
    exp_t        e;
    bit          got;
    vals[0] = 32'h0000_0000; exps[0] = {2'd0, 5'd0,  1'b1, 32'h0000_0000};
    vals[1] = 32'h8000_0000; exps[1] = {2'd0, 5'd31, 1'b0, 32'h8000_0000};
    vals[2] = 32'h0001_2345; exps[2] = {2'd0, 5'd16, 1'b0, 32'h91A2_8000};
    for (int v = 0; v < 3; v++) begin
      @(negedge clk);
      req_data[31:0] = vals[v];
      req_valid = 4'b0001;
      #1;
      n_total++;
      if (req_ready !== 4'b0001) $display("FAIL values_grant: got %b want 0001", req_ready);
      else n_pass++;
      sb.push_back(exps[v]);
      @(posedge clk);
      #1 req_valid = 4'b0000;
      req_data[31:0] = 32'hDEAD_BEEF;
      got = 1'b0;
      for (int c = 0; c < 5 && !got; c++) begin
        @(negedge clk);
        if (res_valid) got = 1'b1;
      end
      n_total++;
      if (!got) $display("FAIL values_timeout: got no res_valid want result for %h", vals[v]);
      else if (sb.size() == 0) $display("FAIL values_result: scoreboard empty");
      else begin
        e = sb.pop_front();
        if (observed() !== e) $display("FAIL values_result: got %h want %h", observed(), e);
        else n_pass++;
      end
    end
  endtask

  task automatic test_round_robin();
    int   order [5];
    int   ng, last, bad;
    exp_t e;
    order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0;
    ng = 0; last = -1; bad = 0;
    @(negedge clk);
    rst_l = 1'b0;
    @(negedge clk);
    req_data = {32'h7000_0000, 32'h0005_0000, 32'h0000_0300, 32'h0000_0010};
    req_valid = 4'b1111;
    res_ready = 1'b1;
    rst_l = 1'b1;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (busy && req_ready != 4'b0000) bad++;
      if (res_valid) begin
        n_total++;
        if (sb.size() == 0) $display("FAIL rr_result: scoreboard empty");
        else begin
          e = sb.pop_front();
          if (observed() !== e) $display("FAIL rr_result: got %h want %h", observed(), e);
          else n_pass++;
        end
      end
      if (req_ready != 4'b0000) begin
        n_total++;
        if (ng >= 5) $display("FAIL rr_grant: got extra grant %b want none", req_ready);
        else if (req_ready !== (4'b0001 << order[ng]) || (last >= 0 && c - last != 3))
          $display("FAIL rr_grant: got %b after %0d cycles want %b after 3", req_ready, c - last, 4'b0001 << order[ng]);
        else n_pass++;
        if (ng < 5) sb.push_back(model(req_data[order[ng]*32 +: 32], 2'(order[ng])));
        last = c;
        ng++;
        if (ng == 5) begin
          @(posedge clk);
          #1 req_valid = 4'b0000;
        end
      end
      if (ng >= 5 && sb.size() == 0) break;
      @(negedge clk);
    end
    n_total++;
    if (ng != 5 || sb.size() != 0) $display("FAIL rr_count: got %0d grants %0d pending want 5 and 0", ng, sb.size());
    else n_pass++;
    n_total++;
    if (bad != 0) $display("FAIL rr_ready_busy: got %0d ready-while-busy cycles want 0", bad);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    exp_t e;
    bit   got;
    @(negedge clk);
    res_ready = 1'b0;
    req_data[95:64] = 32'h0001_2345;
    req_valid = 4'b0100;
    #1;
    n_total++;
    if (req_ready !== 4'b0100) $display("FAIL bp_grant: got %b want 0100", req_ready);
    else n_pass++;
    sb.push_back(model(32'h0001_2345, 2'd2));
    @(posedge clk);
    #1 req_valid = 4'b1011;
    req_data[95:64] = 32'h0000_0000;
    got = 1'b0;
    for (int c = 0; c < 5 && !got; c++) begin
      @(negedge clk);
      if (res_valid) got = 1'b1;
    end
    e = '0;
    n_total++;
    if (!got) $display("FAIL bp_timeout: got no res_valid want 1");
    else if (sb.size() == 0) $display("FAIL bp_result: scoreboard empty");
    else begin
      e = sb.pop_front();
      if (observed() !== e) $display("FAIL bp_result: got %h want %h", observed(), e);
      else n_pass++;
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_total++;
      if ({res_valid, busy, req_ready} !== {1'b1, 1'b1, 4'b0000} || observed() !== e)
        $display("FAIL bp_hold: cycle %0d got v=%b b=%b r=%b res=%h want 1 1 0000 %h",
                 c, res_valid, busy, req_ready, observed(), e);
      else n_pass++;
    end
    res_ready = 1'b1;
    @(negedge clk);
    n_total++;
    if ({res_valid, busy} !== 2'b00) $display("FAIL bp_release: got v=%b b=%b want 0 0", res_valid, busy);
    else n_pass++;
    n_total++;
    if (req_ready !== 4'b1000) $display("FAIL bp_next_grant: got %b want 1000", req_ready);
    else n_pass++;
    req_valid = 4'b0000;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    bit   got;
    @(negedge clk);
    req_data[95:64] = 32'h0000_0F00;
    req_data[63:32] = 32'h0040_0000;
    req_valid = 4'b0100;
    #1;
    n_total++;
    if (req_ready !== 4'b0100) $display("FAIL rstmid_grant: got %b want 0100", req_ready);
    else n_pass++;
    @(posedge clk);
    #2 req_valid = 4'b0000;
    rst_l = 1'b0;
    #1;
    n_total++;
    if ({res_valid, busy, req_ready} !== {1'b0, 1'b0, 4'b0000})
      $display("FAIL rstmid_async: got v=%b b=%b r=%b want 0 0 0000", res_valid, busy, req_ready);
    else n_pass++;
    @(negedge clk);
    req_valid = 4'b0110;
    #1;
    n_total++;
    if ({res_valid, req_ready} !== 5'b0) $display("FAIL rstmid_held: got v=%b r=%b want 0 0000", res_valid, req_ready);
    else n_pass++;
    @(negedge clk);
    rst_l = 1'b1;
    #1;
    n_total++;
    if (req_ready !== 4'b0010) $display("FAIL rstmid_first: got %b want 0010", req_ready);
    else n_pass++;
    sb.push_back(model(32'h0040_0000, 2'd1));
    @(posedge clk);
    #1 req_valid = 4'b0000;
    got = 1'b0;
    for (int c = 0; c < 5 && !got; c++) begin
      @(negedge clk);
      if (res_valid) got = 1'b1;
    end
    n_total++;
    if (!got) $display("FAIL rstmid_timeout: got no res_valid want 1");
    else if (sb.size() == 0) $display("FAIL rstmid_result: scoreboard empty");
    else begin
      e = sb.pop_front();
      if (observed() !== e) $display("FAIL rstmid_result: got %h want %h", observed(), e);
      else n_pass++;
    end
  endtask

  task automatic test_sweep();
    logic [31:0] d;
    int          r;
    exp_t        e;
    bit          got;
    for (int t = 0; t < 44; t++) begin
      d = (t < 32) ? (32'h1 << t) : $urandom();
      r = t % 4;
      @(negedge clk);
      req_data[r*32 +: 32] = d;
      req_valid = 4'b0001 << r;
      #1;
      n_total++;
      if (req_ready !== (4'b0001 << r)) $display("FAIL sweep_grant: t=%0d got %b want %b", t, req_ready, 4'b0001 << r);
      else n_pass++;
      sb.push_back(model(d, 2'(r)));
      @(posedge clk);
      #1 req_valid = 4'b0000;
      req_data[r*32 +: 32] = ~d;
      got = 1'b0;
      for (int c = 0; c < 5 && !got; c++) begin
        @(negedge clk);
        if (res_valid) got = 1'b1;
      end
      n_total++;
      if (!got) $display("FAIL sweep_timeout: t=%0d got no res_valid want 1", t);
      else if (sb.size() == 0) $display("FAIL sweep_result: scoreboard empty");
      else begin
        e = sb.pop_front();
        if (observed() !== e) $display("FAIL sweep_result: t=%0d data=%h got %h want %h", t, d, observed(), e);
        else n_pass++;
      end
    end
  endtask

  initial begin
    rst_l     = 1'b0;
    req_valid = 4'b1111;
    req_data  = '0;
    res_ready = 1'b1;
    test_reset();
    test_single();
    test_values();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_sweep();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got %0d/%0d checks", n_pass, n_total);
    $fatal(1);
  end

endmodule
